seven_segment_display_capture: RTL and testbench

- Receive side of the multiplexed seven-segment interface: samples segment and anode lines, decodes the multiplexed digits, and rebuilds the packed BCD number.
- Used as an on-chip loopback monitor for self-test, and as the bench-side checker for the display path.
- Each digit must be stable for a set number of clocks before it is accepted; decoded digits are published one whole frame at a time.

---
 rtl/seven_segment_pkg.sv | 26 ++
 rtl/seven_segment_display_capture_if.sv | 28 ++
 rtl/segment_to_bcd.sv | 31 +++
 rtl/seven_segment_display_capture.sv | 200 ++++++++++++++++++++
 tb/tb_seven_segment_display_capture.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants and types for the seven-segment capture path.
// Segment patterns are active-low, bit6..bit0 = g,f,e,d,c,b,a.
package seven_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

endpackage

// File: rtl/seven_segment_display_capture_if.sv
// Display-side signal bundle for the seven-segment capture block.
// master: whoever drives the display lines and reads results; slave: the capture block.
interface seven_segment_display_capture_if #(
  parameter int SEGMENT_NUM = 4
);
  localparam int IDX_W = (SEGMENT_NUM > 1) ? $clog2(SEGMENT_NUM) : 1;

  logic [6:0]               i_Segments;
  logic [SEGMENT_NUM-1:0]   i_Anodes;
  logic                     i_Clear;
  logic [4*SEGMENT_NUM-1:0] o_BCD_Num;
  logic                     o_Frame_Valid;
  logic                     o_Digit_Valid;
  logic [IDX_W-1:0]         o_Digit_Index;
  logic                     o_Seg_Err;
  logic                     o_Anode_Err;

  modport master (
    output i_Segments, i_Anodes, i_Clear,
    input  o_BCD_Num, o_Frame_Valid, o_Digit_Valid, o_Digit_Index, o_Seg_Err, o_Anode_Err
  );

  modport slave (
    input  i_Segments, i_Anodes, i_Clear,
    output o_BCD_Num, o_Frame_Valid, o_Digit_Valid, o_Digit_Index, o_Seg_Err, o_Anode_Err
  );

endinterface

// File: rtl/segment_to_bcd.sv
// Combinational decode of an active-low 7-segment pattern to BCD.
// Blank decodes to F without error; unknown patterns decode to E with err_o set.
module segment_to_bcd
  import seven_segment_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       err_o
);

  // pattern lookup, error by default
  always_comb begin
    bcd_o = BCD_ERR;
    err_o = 1'b1;
    case (seg_i)
      SEG_0:     begin bcd_o = 4'd0;      err_o = 1'b0; end
      SEG_1:     begin bcd_o = 4'd1;      err_o = 1'b0; end
      SEG_2:     begin bcd_o = 4'd2;      err_o = 1'b0; end
      SEG_3:     begin bcd_o = 4'd3;      err_o = 1'b0; end
      SEG_4:     begin bcd_o = 4'd4;      err_o = 1'b0; end
      SEG_5:     begin bcd_o = 4'd5;      err_o = 1'b0; end
      SEG_6:     begin bcd_o = 4'd6;      err_o = 1'b0; end
      SEG_7:     begin bcd_o = 4'd7;      err_o = 1'b0; end
      SEG_8:     begin bcd_o = 4'd8;      err_o = 1'b0; end
      SEG_9:     begin bcd_o = 4'd9;      err_o = 1'b0; end
      SEG_BLANK: begin bcd_o = BCD_BLANK; err_o = 1'b0; end
      default:   begin bcd_o = BCD_ERR;   err_o = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seven_segment_display_capture.sv
// Receive side of a multiplexed seven-segment display: samples anode/segment
// lines, waits for each digit to be stable, decodes it, and publishes whole
// frames of packed BCD.
// Optional macro SEVEN_SEGMENT_CAPTURE_SYNC_EN adds a two-flop synchroniser
// ahead of the sample register (all latencies +2 clocks).
module seven_segment_display_capture #(
  parameter int SEGMENT_NUM   = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                          i_Clk,
  input logic                          i_Reset,
  seven_segment_display_capture_if.slave bus
);
  import seven_segment_pkg::*;

  localparam int IDX_W = (SEGMENT_NUM > 1) ? $clog2(SEGMENT_NUM) : 1;
  localparam int SMP_W = SEGMENT_NUM + 7;
  localparam int BCD_W = 4 * SEGMENT_NUM;
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [SMP_W-1:0]       raw;
  logic [SMP_W-1:0]       smp_d;
  logic [SMP_W-1:0]       smp_q;
  logic [SMP_W-1:0]       prev_q;
  logic [SEGMENT_NUM-1:0] s_anodes;
  logic [6:0]             s_segs;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   eval;

  logic [3:0]             dec_bcd;
  logic                   dec_err;
  logic [IDX_W-1:0]       hot_idx;
  logic                   one_hot;
  logic                   all_off;
  logic                   commit;
  logic                   anode_bad;
  logic                   frame_done;

  logic [BCD_W-1:0]       shadow_q, shadow_d;
  logic [SEGMENT_NUM-1:0] mask_q, mask_d, mask_upd;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic                   frame_valid_q;
  logic                   digit_valid_q;
  logic [IDX_W-1:0]       digit_idx_q;
  logic                   seg_err_q;
  logic                   anode_err_q;

  assign raw = {bus.i_Anodes, bus.i_Segments};

`ifdef SEVEN_SEGMENT_CAPTURE_SYNC_EN
  logic [SMP_W-1:0] sync1_q, sync2_q;

  // two-flop synchroniser for asynchronous display lines
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign smp_d = sync2_q;
`else
  assign smp_d = raw;
`endif

  // current sample S and previous sample P
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      smp_q  <= '1;
      prev_q <= '1;
    end else begin
      smp_q  <= smp_d;
      prev_q <= smp_q;
    end
  end

  assign s_anodes = smp_q[SMP_W-1:7];
  assign s_segs   = smp_q[6:0];

  segment_to_bcd u_dec (
    .seg_i (s_segs),
    .bcd_o (dec_bcd),
    .err_o (dec_err)
  );

  // stability FSM state register
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // stability FSM: count identical samples, evaluate once per stable run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eval    = 1'b0;
    case (state_q)
      IDLE: begin
        if (smp_q != prev_q) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (smp_q != prev_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          eval    = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (smp_q != prev_q) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // anode classification: blank, single active digit, or illegal
  always_comb begin
    hot_idx = '0;
    for (int unsigned i = 0; i < SEGMENT_NUM; i++) begin
      if (!s_anodes[i]) hot_idx = IDX_W'(i);
    end
  end

  assign one_hot   = $onehot(~s_anodes);
  assign all_off   = &s_anodes;
  assign commit    = eval && one_hot;
  assign anode_bad = eval && !all_off && !one_hot;

  // shadow/mask update; completed frame includes the digit written this cycle
  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned i = 0; i < SEGMENT_NUM; i++) begin
      if (commit && !s_anodes[i]) shadow_d[4*i +: 4] = dec_bcd;
    end
    mask_upd   = mask_q | ~s_anodes;
    frame_done = commit && (&mask_upd);
    mask_d     = mask_q;
    if (commit) mask_d = frame_done ? '0 : mask_upd;
    bcd_d      = frame_done ? shadow_d : bcd_q;
  end

  // frame assembly, result and pulse registers
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      shadow_q      <= '1;
      mask_q        <= '0;
      bcd_q         <= '1;
      frame_valid_q <= 1'b0;
      digit_valid_q <= 1'b0;
      digit_idx_q   <= '0;
    end else begin
      shadow_q      <= shadow_d;
      mask_q        <= mask_d;
      bcd_q         <= bcd_d;
      frame_valid_q <= frame_done;
      digit_valid_q <= commit;
      if (commit) digit_idx_q <= hot_idx;
    end
  end

  // sticky error flags; a new error wins over a simultaneous clear
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      seg_err_q   <= 1'b0;
      anode_err_q <= 1'b0;
    end else begin
      seg_err_q   <= (commit && dec_err) || (seg_err_q && !bus.i_Clear);
      anode_err_q <= anode_bad || (anode_err_q && !bus.i_Clear);
    end
  end

  assign bus.o_BCD_Num     = bcd_q;
  assign bus.o_Frame_Valid = frame_valid_q;
  assign bus.o_Digit_Valid = digit_valid_q;
  assign bus.o_Digit_Index = digit_idx_q;
  assign bus.o_Seg_Err     = seg_err_q;
  assign bus.o_Anode_Err   = anode_err_q;

endmodule

// File: tb/tb_seven_segment_display_capture.sv
// Self-checking bench for seven_segment_display_capture: directed scans plus
// random dwells, checked every clock against a run-length reference model.
module tb_seven_segment_display_capture;

  localparam int SEGMENT_NUM   = 4;
  localparam int STABLE_CYCLES = 4;
  localparam int BW = 4 * SEGMENT_NUM;
  localparam int SW = SEGMENT_NUM + 7;
`ifdef SEVEN_SEGMENT_CAPTURE_SYNC_EN
  localparam int LAT = STABLE_CYCLES + 3;
`else
  localparam int LAT = STABLE_CYCLES + 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   n_frames = 0;

  seven_segment_display_capture_if #(.SEGMENT_NUM(SEGMENT_NUM)) bus ();

  seven_segment_display_capture #(
    .SEGMENT_NUM   (SEGMENT_NUM),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [6:0]             pat [10];
  logic [BW-1:0]          m_shadow, m_bcd, ones;
  logic [SEGMENT_NUM-1:0] m_mask;
  logic [SW-1:0]          m_prev;
  int                     m_start, m_len;
  bit                     m_done, m_seg, m_an;
  int                     clr_cyc;
  int                     exp_idx [int];
  logic [BW-1:0]          exp_bcd [int];
  bit                     exp_seg [int];
  bit                     exp_an  [int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    if (s == 7'h7F) return {1'b0, 4'hF};
    for (int d = 0; d < 10; d++) if (pat[d] == s) return {1'b0, 4'(d)};
    return {1'b1, 4'hE};
  endfunction

  // what a stable run of (an, seg) does, visible at cycle t
  task automatic model_eval(input int t, input logic [SEGMENT_NUM-1:0] an, input logic [6:0] seg);
    int zeros;
    int k;
    logic [4:0] r;
    zeros = SEGMENT_NUM - $countones(an);
    if (zeros == 1) begin
      k = 0;
      for (int i = 0; i < SEGMENT_NUM; i++) if (an[i] == 1'b0) k = i;
      r = ref_decode(seg);
      m_shadow[4*k +: 4] = r[3:0];
      m_mask[k] = 1'b1;
      exp_idx[t] = k;
      if (r[4]) exp_seg[t] = 1'b1;
      if (m_mask == '1) begin
        exp_bcd[t] = m_shadow;
        m_mask = '0;
      end
    end else if (zeros > 1) begin
      exp_an[t] = 1'b1;
    end
  endtask

  task automatic check_cycle();
    bit dv_e;
    if (exp_seg.exists(cyc)) m_seg = 1'b1; else if (clr_cyc == cyc) m_seg = 1'b0;
    if (exp_an.exists(cyc))  m_an  = 1'b1; else if (clr_cyc == cyc) m_an  = 1'b0;
    if (exp_bcd.exists(cyc)) m_bcd = exp_bcd[cyc];
    dv_e = exp_idx.exists(cyc);
    if (bus.o_Frame_Valid === 1'b1) n_frames++;
    chk("digit_valid", 64'(bus.o_Digit_Valid), 64'(dv_e));
    if (dv_e) chk("digit_index", 64'(bus.o_Digit_Index), 64'(exp_idx[cyc]));
    chk("frame_valid", 64'(bus.o_Frame_Valid), 64'(exp_bcd.exists(cyc)));
    chk("bcd_num", 64'(bus.o_BCD_Num), 64'(m_bcd));
    chk("seg_err", 64'(bus.o_Seg_Err), 64'(m_seg));
    chk("anode_err", 64'(bus.o_Anode_Err), 64'(m_an));
  endtask

  // hold (an, seg) for len clocks; optional one-clock clear at the start
  task automatic run(input logic [SEGMENT_NUM-1:0] an, input logic [6:0] seg,
                     input int len, input bit clr);
    logic [SW-1:0] v;
    v = {an, seg};
    bus.i_Anodes   = an;
    bus.i_Segments = seg;
    bus.i_Clear    = clr;
    if (clr) clr_cyc = cyc + 1;
    if (v !== m_prev) begin
      m_prev  = v;
      m_start = cyc + 1;
      m_len   = 0;
      m_done  = 1'b0;
    end
    m_len += len;
    if (!m_done && m_len >= STABLE_CYCLES + 1) begin
      m_done = 1'b1;
      model_eval(m_start + LAT, an, seg);
    end
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      bus.i_Clear = 1'b0;
      check_cycle();
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.i_Anodes   = '1;
    bus.i_Segments = '1;
    bus.i_Clear    = 1'b0;
    exp_idx.delete();
    exp_bcd.delete();
    exp_seg.delete();
    exp_an.delete();
    m_shadow = '1;
    m_bcd    = '1;
    m_mask   = '0;
    m_prev   = '1;
    m_len    = 0;
    m_done   = 1'b1;
    m_seg    = 1'b0;
    m_an     = 1'b0;
    clr_cyc  = -1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bcd", 64'(bus.o_BCD_Num), 64'(ones));
    chk("rst_frame_valid", 64'(bus.o_Frame_Valid), 64'(0));
    chk("rst_digit_valid", 64'(bus.o_Digit_Valid), 64'(0));
    chk("rst_digit_index", 64'(bus.o_Digit_Index), 64'(0));
    chk("rst_seg_err", 64'(bus.o_Seg_Err), 64'(0));
    chk("rst_anode_err", 64'(bus.o_Anode_Err), 64'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    logic [SEGMENT_NUM-1:0] an;
    logic [6:0] seg;
    logic [6:0] blank;
    pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100; pat[3] = 7'b0110000;
    pat[4] = 7'b0011001; pat[5] = 7'b0010010; pat[6] = 7'b0000010; pat[7] = 7'b1111000;
    pat[8] = 7'b0000000; pat[9] = 7'b0010000;
    blank = 7'b1111111;
    ones  = '1;

    do_reset();

    // scan 1,2,3,4
    run(4'b1110, pat[1], 8, 1'b0);
    run(4'b1101, pat[2], 8, 1'b0);
    run(4'b1011, pat[3], 8, 1'b0);
    run(4'b0111, pat[4], 8, 1'b0);
    chk("scan_frame", 64'(bus.o_BCD_Num), 64'(16'h4321));

    // two-clock glitch between blank dwells
    run(4'b1111, blank, 8, 1'b0);
    run(4'b1100, 7'b0101010, 2, 1'b0);
    run(4'b1111, blank, 8, 1'b0);
    chk("glitch_frame", 64'(bus.o_BCD_Num), 64'(16'h4321));
    chk("glitch_anode_err", 64'(bus.o_Anode_Err), 64'(0));

    // illegal anode value, then clear
    run(4'b1100, pat[8], 8, 1'b0);
    chk("anode_err_set", 64'(bus.o_Anode_Err), 64'(1));
    run(4'b1111, blank, 4, 1'b1);
    chk("anode_err_clr", 64'(bus.o_Anode_Err), 64'(0));

    // bad segment pattern on digit 2
    run(4'b1110, pat[0], 8, 1'b0);
    run(4'b1101, pat[0], 8, 1'b0);
    run(4'b1011, 7'b0101010, 8, 1'b0);
    run(4'b0111, pat[0], 8, 1'b0);
    chk("seg_err_frame", 64'(bus.o_BCD_Num), 64'(16'h0E00));
    chk("seg_err_set", 64'(bus.o_Seg_Err), 64'(1));
    run(4'b1111, blank, 4, 1'b1);

    // blank digit decodes to F without error
    run(4'b1101, blank, 8, 1'b0);
    run(4'b1110, pat[1], 8, 1'b0);
    run(4'b1011, pat[2], 8, 1'b0);
    run(4'b0111, pat[3], 8, 1'b0);
    chk("blank_frame", 64'(bus.o_BCD_Num), 64'(16'h32F1));
    chk("blank_seg_err", 64'(bus.o_Seg_Err), 64'(0));

    // digit 0 committed twice before frame completes
    n_frames = 0;
    run(4'b1110, pat[5], 8, 1'b0);
    run(4'b1110, pat[7], 8, 1'b0);
    run(4'b1101, pat[0], 8, 1'b0);
    run(4'b1011, pat[0], 8, 1'b0);
    run(4'b0111, pat[0], 8, 1'b0);
    run(4'b1111, blank, 8, 1'b0);
    chk("overwrite_frame", 64'(bus.o_BCD_Num), 64'(16'h0007));
    chk("overwrite_frame_count", 64'(n_frames), 64'(1));

    // reset mid-frame, then full scan
    run(4'b1110, pat[9], 8, 1'b0);
    run(4'b1101, pat[8], 8, 1'b0);
    n_frames = 0;
    do_reset();
    run(4'b1110, pat[1], 8, 1'b0);
    run(4'b1101, pat[2], 8, 1'b0);
    run(4'b1011, pat[3], 8, 1'b0);
    run(4'b0111, pat[4], 8, 1'b0);
    chk("post_reset_frame", 64'(bus.o_BCD_Num), 64'(16'h4321));
    chk("post_reset_frame_count", 64'(n_frames), 64'(1));

    // random dwells
    for (int r = 0; r < 80; r++) begin
      case ($urandom_range(0, 9))
        0:       an = '1;
        1:       an = SEGMENT_NUM'($urandom);
        default: begin
          an = '1;
          an[$urandom_range(0, SEGMENT_NUM - 1)] = 1'b0;
        end
      endcase
      case ($urandom_range(0, 9))
        8:       seg = blank;
        9:       seg = 7'($urandom);
        default: seg = pat[$urandom_range(0, 9)];
      endcase
      run(an, seg, $urandom_range(1, 9), ($urandom_range(0, 15) == 0));
    end
    run('1, blank, 12, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
